// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, single-ported memory between
// the fetch port and the data port. One access is in flight at a time.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner;     // 0 = fetch, 1 = data
  logic              last_gnt;  // 0 = fetch, 1 = data
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        cnt;
  logic              pick_d;
  logic              accept;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    pick_d = d_req && (!if_req || !last_gnt);
    accept = (state == IDLE) && (if_req || d_req);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_r ? IDLE : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state)
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_r;
        if_gnt = !owner;
        d_gnt  = owner;
      end
      RESP: begin
        if_rvalid = !owner;
        d_rvalid  = owner;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      cnt      <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (accept) begin
        owner    <= pick_d;
        last_gnt <= pick_d;
        we_r     <= pick_d && d_we;
        addr_r   <= pick_d ? d_addr : if_addr;
        wdata_r  <= pick_d ? d_wdata : '0;
      end
      if (state == ISSUE)     cnt <= 4'(MEM_LAT);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      // Read data is valid in the last WAIT cycle; only the owner's register moves.
      if (state == WAIT && cnt == 4'd1) begin
        if (owner) d_rdata  <= mem_rdata;
        else       if_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three builds (MEM_LAT 2, 1, 15) checked every cycle
// against a transaction-timing model, plus directed literal expectations.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        if_gnt    [3];
  logic        if_rvalid [3];
  logic [31:0] if_rdata  [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic        d_gnt     [3];
  logic        d_rvalid  [3];
  logic [31:0] d_rdata   [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          model_ok = 1'b0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_gnt   (if_gnt[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  function automatic int unsigned lat(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Cycles after the sampling cycle during which a transaction occupies the block.
  function automatic int unsigned txn_len(input bit we, input int unsigned l);
    return we ? 1 : l + 2;
  endfunction

  function automatic logic [31:0] pat(input int unsigned a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (32'hA000_0000 | a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not arrive within bound (cycle %0d)", nm, cyc);
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] env_mem [3][256];
  bit          env_init = 1'b0;
  int unsigned iss_c [3];
  logic [31:0] iss_a [3];
  bit          iss_v [3];

  always @(negedge CLK) begin
    if (!env_init) begin
      for (int k = 0; k < 3; k++) begin
        for (int unsigned i = 0; i < 256; i++) env_mem[k][i] = pat(i);
        iss_v[k] = 1'b0;
      end
      env_init = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      if (mem_en[k] && mem_we[k]) env_mem[k][mem_addr[k][7:0]] = mem_wdata[k];
      if (mem_en[k] && !mem_we[k]) begin
        iss_c[k] = cyc;
        iss_a[k] = mem_addr[k];
        iss_v[k] = 1'b1;
      end
      // Data is only correct in the exact cycle MEM_LAT after issue.
      mem_rdata[k] = (iss_v[k] && cyc == iss_c[k] + lat(k)) ? env_mem[k][iss_a[k][7:0]]
                                                            : (32'hBAD0_0000 ^ cyc);
    end
  end

  // ---------------- transaction-level model ----------------
  logic [31:0] exp_mem [3][256];
  bit          exp_init = 1'b0;
  bit          m_act  [3];
  int unsigned m_t0   [3];
  bit          m_own  [3];
  bit          m_last [3];
  bit          m_we   [3];
  logic [31:0] m_addr [3];
  logic [31:0] m_wdata[3];
  logic [31:0] m_rd   [3][2];

  always @(posedge CLK) begin
    if (!exp_init) begin
      for (int k = 0; k < 3; k++)
        for (int unsigned i = 0; i < 256; i++) exp_mem[k][i] = pat(i);
      exp_init = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      if (m_act[k] && m_we[k] && cyc == m_t0[k] + 1)
        exp_mem[k][m_addr[k][7:0]] = m_wdata[k];
      if (RST) begin
        m_act[k] = 1'b0;  m_last[k] = 1'b1;  m_own[k] = 1'b0;  m_we[k] = 1'b0;
        m_addr[k] = '0;   m_wdata[k] = '0;   m_rd[k][0] = '0;  m_rd[k][1] = '0;
      end else if (!m_act[k] || cyc > m_t0[k] + txn_len(m_we[k], lat(k))) begin
        if (if_req[k] || d_req[k]) begin
          m_own[k]   = (if_req[k] && d_req[k]) ? !m_last[k] : d_req[k];
          m_last[k]  = m_own[k];
          m_we[k]    = m_own[k] && d_we[k];
          m_addr[k]  = m_own[k] ? d_addr[k] : if_addr[k];
          m_wdata[k] = d_wdata[k];
          m_t0[k]    = cyc;
          m_act[k]   = 1'b1;
        end
      end else if (!m_we[k] && cyc == m_t0[k] + lat(k) + 1) begin
        m_rd[k][m_own[k]] = exp_mem[k][m_addr[k][7:0]];
      end
    end
    cyc++;
    model_ok = 1'b1;
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      for (int k = 0; k < 3; k++) begin
        int unsigned ph;
        bit busy, e_en, e_rv;
        ph   = cyc - m_t0[k];
        busy = m_act[k] && ph >= 1 && ph <= txn_len(m_we[k], lat(k));
        e_en = busy && ph == 1;
        e_rv = busy && !m_we[k] && ph == lat(k) + 2;
        chk1($sformatf("i%0d mem_en", k),    mem_en[k],    e_en);
        chk1($sformatf("i%0d mem_we", k),    mem_we[k],    e_en && m_we[k]);
        chk1($sformatf("i%0d if_gnt", k),    if_gnt[k],    e_en && !m_own[k]);
        chk1($sformatf("i%0d d_gnt", k),     d_gnt[k],     e_en && m_own[k]);
        chk1($sformatf("i%0d if_rvalid", k), if_rvalid[k], e_rv && !m_own[k]);
        chk1($sformatf("i%0d d_rvalid", k),  d_rvalid[k],  e_rv && m_own[k]);
        chk($sformatf("i%0d mem_addr", k),   mem_addr[k],  m_addr[k]);
        if (e_en && m_we[k]) chk($sformatf("i%0d mem_wdata", k), mem_wdata[k], m_wdata[k]);
        chk($sformatf("i%0d if_rdata", k),   if_rdata[k],  m_rd[k][0]);
        chk($sformatf("i%0d d_rdata", k),    d_rdata[k],   m_rd[k][1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk_zero(input int k, input string tag);
    chk1({tag, " mem_en"}, mem_en[k], 1'b0);
    chk1({tag, " mem_we"}, mem_we[k], 1'b0);
    chk1({tag, " if_gnt"}, if_gnt[k], 1'b0);
    chk1({tag, " d_gnt"}, d_gnt[k], 1'b0);
    chk1({tag, " if_rvalid"}, if_rvalid[k], 1'b0);
    chk1({tag, " d_rvalid"}, d_rvalid[k], 1'b0);
    chk({tag, " mem_addr"}, mem_addr[k], 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata[k], 32'h0);
    chk({tag, " if_rdata"}, if_rdata[k], 32'h0);
    chk({tag, " d_rdata"}, d_rdata[k], 32'h0);
  endtask

  task automatic xfer(input int k, input bit port, input bit we,
                      input logic [31:0] addr, input logic [31:0] wd);
    bit seen;
    if (port) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge CLK);
      seen = port ? d_gnt[k] : if_gnt[k];
    end
    if_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
    if (!seen) expire($sformatf("i%0d gnt wait", k));
    else if (!we) begin
      seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
        @(negedge CLK);
        seen = port ? d_rvalid[k] : if_rvalid[k];
      end
      if (!seen) expire($sformatf("i%0d rvalid wait", k));
    end
  endtask

  task automatic lat_test(input int k, input int unsigned gap);
    int n;
    bit seen;
    xfer(k, 1'b0, 1'b0, 32'h50, 32'h0);
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h40;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      seen = d_gnt[k];
    end
    d_req[k] = 1'b0;
    if (!seen) expire($sformatf("i%0d lat d_gnt", k));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge CLK);
      n++;
      seen = d_rvalid[k];
    end
    chk($sformatf("i%0d gnt_to_rvalid", k), 32'(n), 32'(gap));
    chk($sformatf("i%0d d_rdata", k), d_rdata[k], 32'hA000_0040);
    chk($sformatf("i%0d if_rdata kept", k), if_rdata[k], 32'hA000_0050);
    repeat (3) @(negedge CLK);
    chk($sformatf("i%0d d_rdata held", k), d_rdata[k], 32'hA000_0040);
  endtask

  task automatic arb_test();
    bit gq[$];
    bit exp_ord [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 32'h60;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h70;
    for (int n = 0; n < 80 && gq.size() < 4; n++) begin
      @(negedge CLK);
      if (if_gnt[0]) gq.push_back(1'b0);
      if (d_gnt[0]) gq.push_back(1'b1);
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    if (gq.size() < 4) expire("arb grant sequence");
    else for (int i = 0; i < 4; i++) chk1($sformatf("arb grant %0d", i), gq[i], exp_ord[i]);
    repeat (8) @(negedge CLK);
  endtask

  task automatic burst_test();
    int unsigned gc[$];
    if_req[0] = 1'b1; if_addr[0] = 32'h14;
    for (int n = 0; n < 60 && gc.size() < 3; n++) begin
      @(negedge CLK);
      if (if_gnt[0]) gc.push_back(n);
    end
    if_req[0] = 1'b0;
    if (gc.size() < 3) expire("burst grants");
    else begin
      chk("burst spacing 1", gc[1] - gc[0], 32'd5);
      chk("burst spacing 2", gc[2] - gc[1], 32'd5);
    end
    repeat (8) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) chk_zero(k, $sformatf("reset i%0d", k));
    RST = 1'b0;

    // Fetch read of 0x10 on the MEM_LAT=2 build.
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    @(negedge CLK);
    chk1("t1 if_gnt", if_gnt[0], 1'b1);
    chk1("t1 mem_en", mem_en[0], 1'b1);
    chk("t1 mem_addr", mem_addr[0], 32'h10);
    if_req[0] = 1'b0;
    repeat (3) @(negedge CLK);
    chk1("t4 if_rvalid", if_rvalid[0], 1'b1);
    chk("t4 if_rdata", if_rdata[0], 32'hDEAD_BEEF);
    chk1("t4 d_rvalid", d_rvalid[0], 1'b0);
    chk("t4 d_rdata", d_rdata[0], 32'h0);
    @(negedge CLK);

    // Data write then read-back of 0x20.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'h5A5A_5A5A;
    @(negedge CLK);
    chk1("wr mem_en", mem_en[0], 1'b1);
    chk1("wr mem_we", mem_we[0], 1'b1);
    chk("wr mem_addr", mem_addr[0], 32'h20);
    chk("wr mem_wdata", mem_wdata[0], 32'h5A5A_5A5A);
    chk1("wr d_gnt", d_gnt[0], 1'b1);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    @(negedge CLK);
    chk1("wr no d_rvalid", d_rvalid[0], 1'b0);
    d_req[0] = 1'b1; d_addr[0] = 32'h20;
    @(negedge CLK);
    d_req[0] = 1'b0;
    repeat (3) @(negedge CLK);
    chk1("rd d_rvalid", d_rvalid[0], 1'b1);
    chk("rd d_rdata", d_rdata[0], 32'h5A5A_5A5A);
    repeat (2) @(negedge CLK);

    arb_test();

    // Reset while a fetch read sits in WAIT.
    if_req[0] = 1'b1; if_addr[0] = 32'h30;
    @(negedge CLK);
    chk1("rst if_gnt", if_gnt[0], 1'b1);
    if_req[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_zero(0, "rst in wait");
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    xfer(0, 1'b0, 1'b0, 32'h30, 32'h0);
    chk("post-rst if_rdata", if_rdata[0], 32'hA000_0030);
    repeat (2) @(negedge CLK);

    lat_test(1, 2);
    lat_test(2, 16);

    burst_test();

    repeat (4) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
